// File: rtl/router_pkg.sv
// Shared router types and constants: port directions, routing modes,
// route-compute FSM states and VC/credit sizing.
package router_pkg;

  localparam int NUM_PORTS        = 5;
  localparam int NUM_VCS          = 4;
  localparam int CREDIT_CTR_WIDTH = 4;
  localparam int DIRECTION_BITS   = 3;
  localparam int DIM_BITS_DEF     = 4;
  localparam int SCORE_W          = $clog2(NUM_VCS + 1);

  localparam logic [DIRECTION_BITS-1:0] N = 3'd0;
  localparam logic [DIRECTION_BITS-1:0] E = 3'd1;
  localparam logic [DIRECTION_BITS-1:0] S = 3'd2;
  localparam logic [DIRECTION_BITS-1:0] W = 3'd3;
  localparam logic [DIRECTION_BITS-1:0] R = 3'd4;

  typedef enum logic [1:0] {
    RC_XY,
    RC_YX,
    RC_WEST_FIRST
  } rc_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    OFFER,
    LOCK
  } rc_state_t;

endpackage

// File: rtl/rc_adaptive_unit_if.sv
// Head-flit in / route-out handshake bundle of the route-compute unit.
// slave is the route unit, master is the input buffer / VC allocator side.
interface rc_adaptive_unit_if #(
  parameter int DIM_BITS = router_pkg::DIM_BITS_DEF
) ();
  import router_pkg::*;

  logic                      hd_valid;
  logic                      hd_ready;
  logic [DIM_BITS-1:0]       dst_x;
  logic [DIM_BITS-1:0]       dst_y;
  logic                      hd_single;
  logic                      tail_done;
  logic                      rc_valid;
  logic                      rc_ready;
  logic [DIRECTION_BITS-1:0] rc_out;
  logic                      rc_locked;
  logic                      rc_err;

  modport slave (
    input  hd_valid, dst_x, dst_y, hd_single,
    input  tail_done, rc_ready,
    output hd_ready, rc_valid, rc_out,
    output rc_locked, rc_err
  );

  modport master (
    output hd_valid, dst_x, dst_y, hd_single,
    output tail_done, rc_ready,
    input  hd_ready, rc_valid, rc_out,
    input  rc_locked, rc_err
  );

endinterface

// File: rtl/rc_port_score.sv
// Per-output-port congestion score: number of downstream VCs that are
// both unallocated and hold at least one credit.
module rc_port_score
  import router_pkg::*;
#(
  parameter int VCS = NUM_VCS,
  parameter int CW  = CREDIT_CTR_WIDTH,
  parameter int SW  = $clog2(VCS + 1)
) (
  input  logic [VCS-1:0]         free_i,
  input  logic [VCS-1:0][CW-1:0] credits_i,
  output logic [SW-1:0]          score_o
);

  always_comb begin
    score_o = '0;
    for (int v = 0; v < VCS; v++) begin
      if (free_i[v] && (credits_i[v] != '0))
        score_o = score_o + SW'(1);
    end
  end

endmodule

// File: rtl/rc_adaptive_unit.sv
// Route-compute stage: captures a head flit, picks an output port
// (XY, YX or congestion-aware west-first) and holds it for the packet.
module rc_adaptive_unit
  import router_pkg::*;
#(
  parameter int       DIM_BITS = DIM_BITS_DEF,
  parameter int       MESH_X   = 4,
  parameter int       MESH_Y   = 4,
  parameter rc_mode_t RC_MODE  = RC_XY
) (
  input  logic clk,
  input  logic rst,
  input  logic [DIM_BITS-1:0] LOCAL_X,
  input  logic [DIM_BITS-1:0] LOCAL_Y,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0] out_vc_free,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]
               [CREDIT_CTR_WIDTH-1:0] ovc_credits_count_r,
  rc_adaptive_unit_if.slave hd
);

  localparam logic [DIM_BITS:0] MX = (DIM_BITS+1)'(MESH_X);
  localparam logic [DIM_BITS:0] MY = (DIM_BITS+1)'(MESH_Y);

  rc_state_t                 state_q, state_d;
  logic [DIM_BITS-1:0]       dst_x_q, dst_x_d;
  logic [DIM_BITS-1:0]       dst_y_q, dst_y_d;
  logic                      single_q, single_d;
  logic [DIRECTION_BITS-1:0] out_q, out_d;
  logic                      err_q, err_d;

  logic [DIRECTION_BITS-1:0] route, xy_dir, yx_dir, wf_dir, y_dir;
  logic                      route_err;
  logic                      e_go, w_go, s_go, n_go;
  logic [SCORE_W-1:0]        score_e, score_n, score_s, y_score;

  // West and local rows never take part in the adaptive choice
  logic unused_ports;
  assign unused_ports = ^{out_vc_free[W], out_vc_free[R],
                          ovc_credits_count_r[W],
                          ovc_credits_count_r[R]};

  rc_port_score #(
    .VCS(NUM_VCS), .CW(CREDIT_CTR_WIDTH), .SW(SCORE_W)
  ) u_score_e (
    .free_i    (out_vc_free[E]),
    .credits_i (ovc_credits_count_r[E]),
    .score_o   (score_e)
  );

  rc_port_score #(
    .VCS(NUM_VCS), .CW(CREDIT_CTR_WIDTH), .SW(SCORE_W)
  ) u_score_n (
    .free_i    (out_vc_free[N]),
    .credits_i (ovc_credits_count_r[N]),
    .score_o   (score_n)
  );

  rc_port_score #(
    .VCS(NUM_VCS), .CW(CREDIT_CTR_WIDTH), .SW(SCORE_W)
  ) u_score_s (
    .free_i    (out_vc_free[S]),
    .credits_i (ovc_credits_count_r[S]),
    .score_o   (score_s)
  );

  assign e_go = dst_x_q > LOCAL_X;
  assign w_go = dst_x_q < LOCAL_X;
  assign s_go = dst_y_q > LOCAL_Y;
  assign n_go = dst_y_q < LOCAL_Y;

  assign y_dir   = s_go ? S : N;
  assign y_score = s_go ? score_s : score_n;

  always_comb begin
    xy_dir = R;
    priority case (1'b1)
      e_go:    xy_dir = E;
      w_go:    xy_dir = W;
      s_go:    xy_dir = S;
      n_go:    xy_dir = N;
      default: xy_dir = R;
    endcase
  end

  always_comb begin
    yx_dir = R;
    priority case (1'b1)
      s_go:    yx_dir = S;
      n_go:    yx_dir = N;
      e_go:    yx_dir = E;
      w_go:    yx_dir = W;
      default: yx_dir = R;
    endcase
  end

  // Ties between E and the Y port fall to E
  always_comb begin
    wf_dir = R;
    priority case (1'b1)
      w_go:                   wf_dir = W;
      e_go && (s_go || n_go): wf_dir = (y_score > score_e) ? y_dir : E;
      e_go:                   wf_dir = E;
      s_go:                   wf_dir = S;
      n_go:                   wf_dir = N;
      default:                wf_dir = R;
    endcase
  end

  always_comb begin
    route_err = ({1'b0, dst_x_q} >= MX) || ({1'b0, dst_y_q} >= MY);
    route     = R;
    if (!route_err) begin
      case (RC_MODE)
        RC_XY:         route = xy_dir;
        RC_YX:         route = yx_dir;
        RC_WEST_FIRST: route = wf_dir;
        default:       route = xy_dir;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hd.hd_valid) state_d = COMPUTE;
      COMPUTE: state_d = OFFER;
      OFFER:   if (hd.rc_ready) state_d = single_q ? IDLE : LOCK;
      LOCK:    if (hd.tail_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hd.hd_ready  = (state_q == IDLE);
    hd.rc_valid  = (state_q == OFFER);
    hd.rc_locked = (state_q == LOCK);
    hd.rc_out    = out_q;
    hd.rc_err    = err_q;
  end

  // Route is latched once in COMPUTE so later credit churn cannot move it
  always_comb begin
    dst_x_d  = dst_x_q;
    dst_y_d  = dst_y_q;
    single_d = single_q;
    out_d    = out_q;
    err_d    = err_q;
    if ((state_q == IDLE) && hd.hd_valid) begin
      dst_x_d  = hd.dst_x;
      dst_y_d  = hd.dst_y;
      single_d = hd.hd_single;
    end
    if (state_q == COMPUTE) begin
      out_d = route;
      err_d = route_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_x_q  <= '0;
      dst_y_q  <= '0;
      single_q <= 1'b0;
      out_q    <= R;
      err_q    <= 1'b0;
    end else begin
      dst_x_q  <= dst_x_d;
      dst_y_q  <= dst_y_d;
      single_q <= single_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/rc_adaptive_unit.md
RC_ADAPTIVE_UNIT -- requirements
Module: rc_adaptive_unit

Interface
REQ-001 SHALL have parameter DIM_BITS, default router_pkg value, width of the X and Y coordinates.
REQ-002 SHALL have parameter MESH_X, default 4, number of mesh columns.
REQ-003 SHALL have parameter MESH_Y, default 4, number of mesh rows.
REQ-004 SHALL have parameter RC_MODE, default RC_XY, routing mode: RC_XY, RC_YX or RC_WEST_FIRST.
REQ-005 SHALL use NUM_PORTS, NUM_VCS, CREDIT_CTR_WIDTH and DIRECTION_BITS from router_pkg.
REQ-006 SHALL have one clock and an asynchronous active-high reset; ports clk then rst.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 LOCAL_X, LOCAL_Y  input  DIM_BITS each  this router's coordinates, static.
REQ-010 hd_valid  input  1  head flit present.
REQ-011 hd_ready  output  1  unit can accept a head flit.
REQ-012 dst_x, dst_y  input  DIM_BITS each  head-flit destination.
REQ-013 hd_single  input  1  packet is a single flit (head is also tail).
REQ-014 tail_done  input  1  tail flit of the locked packet has left this input.
REQ-015 out_vc_free  input  [NUM_PORTS][NUM_VCS]  downstream VC is unallocated.
REQ-016 ovc_credits_count_r  input  [NUM_PORTS][NUM_VCS] x CREDIT_CTR_WIDTH  downstream credits.
REQ-017 rc_valid  output  1  rc_out is valid and offered to VC allocation.
REQ-018 rc_ready  input  1  VC allocation accepts rc_out.
REQ-019 rc_out  output  DIRECTION_BITS  selected output port (N/E/S/W/R).
REQ-020 rc_locked  output  1  route is held for the packet body.
REQ-021 rc_err  output  1  destination is outside the mesh.

Function
REQ-022 SHALL implement FSM states IDLE, COMPUTE, OFFER and LOCK.
REQ-023 IDLE: hd_ready=1; on hd_valid, SHALL register dst_x, dst_y and hd_single, then go to COMPUTE.
REQ-024 COMPUTE: hd_ready=0; SHALL register rc_out and rc_err, then go to OFFER (rc_valid is high 2 cycles after the accepting edge).
REQ-025 OFFER: rc_valid=1, with rc_out and rc_err stable; on rc_ready SHALL go to LOCK, or to IDLE if hd_single is registered.
REQ-026 LOCK: rc_valid=0, rc_locked=1, rc_out held; on tail_done SHALL go to IDLE.
REQ-027 tail_done SHALL be ignored outside LOCK; rc_ready SHALL be ignored outside OFFER.
REQ-028 RC_XY SHALL resolve X first: E if dst_x>LOCAL_X, W if dst_x<LOCAL_X, else S if dst_y>LOCAL_Y, N if dst_y<LOCAL_Y, else R.
REQ-029 RC_YX SHALL resolve Y first, with the same per-axis rules as RC_XY.
REQ-030 RC_WEST_FIRST: if dst_x<LOCAL_X, SHALL select W.
REQ-031 RC_WEST_FIRST, otherwise: the productive set is {E if dst_x>LOCAL_X, S/N per Y}; one member is selected directly, an empty set selects R.
REQ-032 RC_WEST_FIRST, two productive ports: SHALL select the higher score; a tie selects E.
REQ-033 score(p) SHALL be the count of VCs v with out_vc_free[p][v]=1 and ovc_credits_count_r[p][v]!=0, sampled in COMPUTE only.
REQ-034 score width SHALL be $clog2(NUM_VCS+1); all comparisons unsigned.
REQ-035 If dst_x>=MESH_X or dst_y>=MESH_Y, SHALL set rc_err=1 and rc_out=R, overriding every mode.
REQ-036 Credit changes after COMPUTE SHALL NOT alter rc_out.

Reset
REQ-037 Reset SHALL force IDLE, hd_ready=1, rc_valid=0, rc_locked=0, rc_err=0, rc_out=R, and clear the captured destination.
REQ-038 Reset asserted in any state, including mid-OFFER or LOCK, SHALL abort the packet without emitting rc_valid.

Structure
REQ-039 The rc_mode_t enum (RC_XY, RC_YX, RC_WEST_FIRST) and the rc_state_t FSM enum SHALL live in router_pkg; N/E/S/W/R stay there.
REQ-040 Scoring SHALL be a sub-module rc_port_score (per-port VC free/credit popcount), instantiated for E, N and S.

Verification
REQ-041 XY, LOCAL=(1,1), dst=(3,0), hd_valid 1 cycle -> rc_valid 2 cycles later, rc_out=E; rc_ready -> rc_locked=1; tail_done -> IDLE.
REQ-042 YX, LOCAL=(1,1), dst=(3,0) -> rc_out=N; XY with dst=(1,1) and hd_single=1 -> rc_out=R, then IDLE directly after rc_ready.
REQ-043 WEST_FIRST, LOCAL=(1,1), dst=(2,3), E has 1 free VC with credit and S has 3 -> rc_out=S; equal scores -> rc_out=E; dst=(0,3) -> rc_out=W regardless of credits.
REQ-044 MESH_X=4, dst_x=5 -> rc_err=1, rc_out=R in every mode.
REQ-045 rc_ready held low for 10 cycles in OFFER while credits toggle -> rc_out and rc_valid stable; hd_ready=0 throughout.
REQ-046 rst pulsed in LOCK and again in OFFER -> next cycle all outputs at reset values, hd_ready=1.
